irrigation_bcd_timer: RTL and testbench
=======================================

Name: irrigation_bcd_timer

Overview:
- Parametrised BCD countdown timer for the irrigation controller; successor to the fixed three-digit drip counter.
- Digit count is set by a parameter. Each mode (drip/sprinkler) has its own preset, loaded on request.
- Adds a tick prescaler, pause, done pulse and valve-enable output.
- Sits between the sensor/control FSM, which drives pulse/mode/pause, and the 7-segment display decoders, which read bcd_out.

Parameters:
- DIGITS, 3, number of BCD digits (1..6).
- PRESET_DRIP, 12'h300, packed BCD preset for mode 0; digit 0 at bits [3:0]; width 4*DIGITS.
- PRESET_SPRINKLER, 12'h150, packed BCD preset for mode 1; same packing.
- TICK_DIV, 4, clk cycles per count decrement (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pulse  input  1  start/reload request, level sampled each clk.
- mode  input  1  preset select: 0 = drip, 1 = sprinkler; sampled only when pulse=1.
- pause  input  1  freeze countdown while high.
- bcd_out  output  4*DIGITS  current count, packed BCD, digit 0 least significant.
- running  output  1  high in RUN and PAUSED.
- valve  output  1  high in RUN only.
- done  output  1  one-cycle pulse on expiry.

Behaviour:
- Reset (async, any time, including mid-count):
  - state=IDLE, bcd_out=0, prescaler=0.
  - running=0, valve=0, done=0.
- States:
  - IDLE: reset state.
  - RUN: counting.
  - PAUSED: count frozen.
  - DONE: expired, waiting for a new start.
- pulse=1 at a rising edge, in any state, takes priority over pause and over tick:
  - bcd_out loads the preset for the current mode; prescaler=0; state=RUN.
  - Visible after the same edge.
- Zero preset: if the loaded preset is all zeros, the next edge goes to DONE and asserts done. valve is high for exactly one cycle.
- RUN, pause=1: go to PAUSED; prescaler holds.
- PAUSED, pause=0: return to RUN. Prescaler resumes from its held value.
- Prescaler:
  - In RUN, increments every clk.
  - When it equals TICK_DIV-1, it wraps to 0 and generates tick.
  - TICK_DIV=1 gives a tick every cycle.
- On tick, decrement bcd_out as a BCD borrow chain:
  - A digit at 0 wraps to 9 and borrows from the next digit.
  - Other digits decrement by 1.
  - Digits above the first non-zero digit are unchanged.
- Expiry: if the decremented value is all zeros, the same edge:
  - sets state=DONE;
  - asserts done for exactly one cycle;
  - drops valve.
  - bcd_out holds 0.
- Timing from load: a preset of N (decimal) reaches zero after exactly N ticks, i.e. N*TICK_DIV clk cycles.
- DONE: holds bcd_out=0, running=0, valve=0. Leaves only on pulse or reset.
- IDLE: no counting. pause is ignored in IDLE and DONE.
- pulse held high for several cycles: reload on every such edge; counting starts after pulse falls.
- mode changes without pulse have no effect.
- Outputs are registered; none are combinational from inputs.
- Presets must be valid BCD (each nibble 0..9). The bench checks this; the RTL does not need to.

Test Plan:
- Reset, then pulse with mode=0, DIGITS=3, TICK_DIV=4 -> bcd_out=12'h300 after the edge; running=1, valve=1; after 4 cycles bcd_out=12'h299.
- Borrow chain: load 12'h100 with TICK_DIV=1 -> next values 0x099, 0x098, ...; after 100 cycles bcd_out=0, done high for exactly 1 cycle, then state=DONE and valve=0.
- Pause: during RUN, assert pause for 10 cycles -> bcd_out and prescaler frozen, running=1, valve=0; on release, the decrement lands exactly the remaining prescaler count later.
- Reload and mode: pulse with mode=1 mid-count at 0x237 -> bcd_out=12'h150 next edge, prescaler cleared. Toggling mode without pulse has no effect.
- Reset mid-count: assert reset asynchronously between edges -> all outputs 0 immediately; no done pulse.
- Zero preset: set PRESET_DRIP=0 and pulse -> one cycle of RUN (valve=1), then done=1 and DONE.

Source files
------------

// File: rtl/irrigation_bcd_timer.sv
// Parametrised BCD countdown timer for the irrigation controller.
// Per-mode presets, tick prescaler, pause, one-cycle done pulse and valve enable.
module irrigation_bcd_timer #(
   parameter int                  DIGITS           = 3,
   parameter logic [4*DIGITS-1:0] PRESET_DRIP      = 12'h300,
   parameter logic [4*DIGITS-1:0] PRESET_SPRINKLER = 12'h150,
   parameter int                  TICK_DIV         = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pulse,
   input  logic                  mode,
   input  logic                  pause,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  running,
   output logic                  valve,
   output logic                  done
);

   localparam int W  = 4 * DIGITS;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
   localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
   localparam logic [W-1:0]  BCD_ZERO   = W'(0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t          state_r, state_s;
   logic [W-1:0]    bcd_r, bcd_s, dec_s;
   logic [PW-1:0]   presc_r, presc_s;
   logic            running_r, running_s;
   logic            valve_r, valve_s;
   logic            done_r, done_s;

   // Ripple-borrow decrement: digits at 0 wrap to 9 and pass the borrow upward.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
               borrow      = 1'b1;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

   // Next-state, next-count and next-output decode.
   always_comb begin
      state_s = state_r;
      bcd_s   = bcd_r;
      presc_s = presc_r;
      done_s  = 1'b0;
      dec_s   = bcd_dec(bcd_r);
      if (pulse) begin
         bcd_s   = mode ? PRESET_SPRINKLER : PRESET_DRIP;
         presc_s = PRESC_ZERO;
         state_s = ST_RUN;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (bcd_r == BCD_ZERO) begin
                  // zero preset expires on the first edge after loading
                  state_s = ST_DONE;
                  done_s  = 1'b1;
               end else if (pause) begin
                  state_s = ST_PAUSED;
               end else if (presc_r == PRESC_LAST) begin
                  presc_s = PRESC_ZERO;
                  bcd_s   = dec_s;
                  if (dec_s == BCD_ZERO) begin
                     state_s = ST_DONE;
                     done_s  = 1'b1;
                  end else begin
                     state_s = ST_RUN;
                  end
               end else begin
                  presc_s = presc_r + PRESC_ONE;
               end
            end
            ST_PAUSED: begin
               if (pause) begin
                  state_s = ST_PAUSED;
               end else begin
                  state_s = ST_RUN;
               end
            end
            ST_IDLE: begin
               state_s = ST_IDLE;
            end
            ST_DONE: begin
               state_s = ST_DONE;
               bcd_s   = BCD_ZERO;
            end
            default: begin
               state_s = ST_IDLE;
               bcd_s   = BCD_ZERO;
               presc_s = PRESC_ZERO;
            end
         endcase
      end
      running_s = (state_s == ST_RUN) || (state_s == ST_PAUSED);
      valve_s   = (state_s == ST_RUN);
   end

   // State, count and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         bcd_r     <= BCD_ZERO;
         presc_r   <= PRESC_ZERO;
         running_r <= 1'b0;
         valve_r   <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         bcd_r     <= bcd_s;
         presc_r   <= presc_s;
         running_r <= running_s;
         valve_r   <= valve_s;
         done_r    <= done_s;
      end
   end

   assign bcd_out = bcd_r;
   assign running = running_r;
   assign valve   = valve_r;
   assign done    = done_r;

endmodule

// File: tb/tb_irrigation_bcd_timer.sv
// Scoreboard bench: three timer instances (default, fast borrow chain, zero preset)
// share stimulus; a decimal-count reference model predicts every cycle.
module tb_irrigation_bcd_timer;

   typedef struct {
      logic [11:0] bcd;
      logic [2:0]  flags;
   } exp_t;

   localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSED = 2, ST_DONE = 3;

   logic        clk, reset, pulse, mode, pause;
   logic [11:0] bcd_v [3];
   logic [2:0]  running_v, valve_v, done_v;

   int total, bad;
   exp_t sbq[$];

   int td [3] = '{4, 1, 4};
   int pd [3] = '{300, 100, 0};
   int ps [3] = '{150, 150, 150};
   int cnt [3];
   int st [3];
   int presc [3];
   logic dn [3];

   irrigation_bcd_timer u_a (
      .clk(clk), .reset(reset), .pulse(pulse), .mode(mode), .pause(pause),
      .bcd_out(bcd_v[0]), .running(running_v[0]), .valve(valve_v[0]), .done(done_v[0]));

   irrigation_bcd_timer #(.DIGITS(3), .PRESET_DRIP(12'h100), .TICK_DIV(1)) u_b (
      .clk(clk), .reset(reset), .pulse(pulse), .mode(mode), .pause(pause),
      .bcd_out(bcd_v[1]), .running(running_v[1]), .valve(valve_v[1]), .done(done_v[1]));

   irrigation_bcd_timer #(.DIGITS(3), .PRESET_DRIP(12'h000)) u_c (
      .clk(clk), .reset(reset), .pulse(pulse), .mode(mode), .pause(pause),
      .bcd_out(bcd_v[2]), .running(running_v[2]), .valve(valve_v[2]), .done(done_v[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] to_bcd(input int v);
      logic [11:0] r;
      r[3:0]  = 4'((v) % 10);
      r[7:4]  = 4'((v / 10) % 10);
      r[11:8] = 4'((v / 100) % 10);
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         cnt[k] = 0; st[k] = ST_IDLE; presc[k] = 0; dn[k] = 1'b0;
      end
   endtask

   task automatic model_step(input int k);
      dn[k] = 1'b0;
      if (pulse) begin
         cnt[k] = mode ? ps[k] : pd[k];
         presc[k] = 0;
         st[k] = ST_RUN;
      end else if (st[k] == ST_RUN) begin
         if (cnt[k] == 0) begin
            st[k] = ST_DONE; dn[k] = 1'b1;
         end else if (pause) begin
            st[k] = ST_PAUSED;
         end else if (presc[k] == td[k] - 1) begin
            presc[k] = 0;
            cnt[k] = cnt[k] - 1;
            if (cnt[k] == 0) begin
               st[k] = ST_DONE; dn[k] = 1'b1;
            end
         end else begin
            presc[k] = presc[k] + 1;
         end
      end else if (st[k] == ST_PAUSED && !pause) begin
         st[k] = ST_RUN;
      end
   endtask

   task automatic check_nibbles(input int k);
      logic ok;
      ok = 1'b1;
      for (int d = 0; d < 3; d++) begin
         if (bcd_v[k][4*d +: 4] > 4'd9) ok = 1'b0;
      end
      total++;
      assert (ok === 1'b1) else begin
         bad++;
         $error("FAIL bcd_valid%0d observed=%h expected=all nibbles 0..9", k, bcd_v[k]);
      end
   endtask

   task automatic step(input logic p, input logic m, input logic pz);
      exp_t e;
      @(negedge clk);
      pulse = p; mode = m; pause = pz;
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         model_step(k);
         e.bcd   = to_bcd(cnt[k]);
         e.flags = {(st[k] == ST_RUN || st[k] == ST_PAUSED), (st[k] == ST_RUN), dn[k]};
         sbq.push_back(e);
      end
      #1;
      for (int k = 0; k < 3; k++) begin
         e = sbq.pop_front();
         total++;
         assert (bcd_v[k] === e.bcd) else begin
            bad++;
            $error("FAIL bcd%0d observed=%h expected=%h", k, bcd_v[k], e.bcd);
         end
         total++;
         assert ({running_v[k], valve_v[k], done_v[k]} === e.flags) else begin
            bad++;
            $error("FAIL flags%0d run/valve/done observed=%b expected=%b", k,
                   {running_v[k], valve_v[k], done_v[k]}, e.flags);
         end
         check_nibbles(k);
      end
   endtask

   task automatic check_zero(input string tag);
      for (int k = 0; k < 3; k++) begin
         total++;
         assert ({bcd_v[k], running_v[k], valve_v[k], done_v[k]} === 15'd0) else begin
            bad++;
            $error("FAIL %s%0d observed=%h/%b%b%b expected=000/000", tag, k,
                   bcd_v[k], running_v[k], valve_v[k], done_v[k]);
         end
      end
   endtask

   task automatic check_a(input string tag, input logic [11:0] want);
      total++;
      assert (bcd_v[0] === want) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, bcd_v[0], want);
      end
   endtask

   initial begin
      int n;
      total = 0; bad = 0;
      reset = 1'b1; pulse = 1'b0; mode = 1'b0; pause = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_zero("reset_state");
      @(negedge clk) reset = 1'b0;

      // idle: no counting, pause ignored
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);

      // load drip preset, first decrement after TICK_DIV cycles
      step(1'b1, 1'b0, 1'b0);
      check_a("load_drip", 12'h300);
      repeat (4) step(1'b0, 1'b0, 1'b0);
      check_a("first_tick", 12'h299);

      // borrow chain on the fast instance runs to expiry
      repeat (100) step(1'b0, 1'b0, 1'b0);

      // pause mid-prescale and release
      step(1'b0, 1'b0, 1'b0);
      repeat (10) step(1'b0, 1'b0, 1'b1);
      repeat (10) step(1'b0, 1'b0, 1'b0);

      // run to 237, reload with sprinkler preset, then wiggle mode alone
      n = 0;
      while (cnt[0] != 237 && n < 2000) begin
         step(1'b0, 1'b0, 1'b0);
         n++;
      end
      check_a("reach_237", 12'h237);
      step(1'b1, 1'b1, 1'b0);
      check_a("reload_sprinkler", 12'h150);
      for (int i = 0; i < 6; i++) step(1'b0, 1'(i % 2), 1'b0);

      // asynchronous reset between edges
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check_zero("async_reset");
      model_reset();
      @(negedge clk) reset = 1'b0;
      step(1'b0, 1'b0, 1'b0);

      // pulse held high reloads every edge, counting starts after release
      repeat (3) step(1'b1, 1'b0, 1'b0);
      repeat (8) step(1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b0);

      // sprinkler start on all instances, fast one runs to expiry
      step(1'b1, 1'b1, 1'b0);
      repeat (155) step(1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
